// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction fetch prefetch unit with redirect handling
//
// Purpose: issues sequential instruction memory requests (one outstanding at a
// time), buffers responses in a DEPTH-entry {pc, instr} FIFO for decode, and
// flushes/refetches on a branch redirect.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   redirect, redirect_rel,         branch taken; relative/absolute select;
//   redirect_target                 absolute target or two's-complement offset
//   imem_req, imem_addr             memory request (held stable until ack)
//   imem_ack, imem_data             memory response
//   out_valid, out_ready            head entry handshake to decode
//   out_pc, out_instr, out_pc_next  head entry contents and its successor PC

module if_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic               redirect_rel,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc_next
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN   = ~ADDR_W'(PC_STEP - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic               ack;
    logic               push;
    logic               pop;
    logic               valid;
    logic [ADDR_W-1:0]  head_pc;
    logic [ADDR_W-1:0]  base;
    logic [ADDR_W-1:0]  target;

    // An ack only counts against a live request; stray acks are ignored.
    assign ack     = imem_ack && req_q;
    assign valid   = (count_q != '0);
    // Responses that land while draining belong to the abandoned path.
    assign push    = ack && (state_q == FETCH) && !redirect;
    assign pop     = valid && out_ready && !redirect;
    assign head_pc = pc_mem[head_q];

    // With an empty FIFO, fetch_pc is the PC decode would see next.
    assign base    = valid ? head_pc : fetch_pc_q;
    assign target  = (redirect_rel ? (base + redirect_target) : redirect_target) & ALIGN;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (redirect) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = target;
        end else begin
            if (push) begin
                tail_d     = tail_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + STEP;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        if (req_q && !ack) begin
            // Request still in flight: keep it on the bus unchanged. A redirect
            // (now or earlier) means its response must be thrown away.
            req_d   = 1'b1;
            state_d = (state_q == DRAIN || redirect) ? DRAIN : FETCH;
        end else if (count_d < DEPTH_C) begin
            // Nothing outstanding after this edge and a slot is free.
            req_d   = 1'b1;
            addr_d  = fetch_pc_d;
            state_d = FETCH;
        end else begin
            req_d   = 1'b0;
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= fetch_pc_q;
            instr_mem[tail_q] <= imem_data;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign out_valid   = valid;
    assign out_pc      = valid ? head_pc : '0;
    assign out_instr   = valid ? instr_mem[head_q] : '0;
    assign out_pc_next = valid ? (head_pc + STEP) : '0;

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - self-checking bench for if_prefetch

module tb_if_prefetch;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic        redirect_rel;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc_next;

    int total = 0;
    int bad   = 0;

    if_prefetch #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect        (redirect),
        .redirect_rel    (redirect_rel),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_pc_next     (out_pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic a, input logic r, input logic rd,
                          input logic rel, input logic [31:0] t);
        imem_ack        = a;
        imem_data       = mem_word(imem_addr);
        out_ready       = r;
        redirect        = rd;
        redirect_rel    = rel;
        redirect_target = t;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
        total++; if (out_pc_next !== 32'h0) begin bad++; $display("FAIL reset_pc_next got=%h exp=0", out_pc_next); end
        reset = 1'b0;
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_first_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_first_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int seen;
        exp_pc = 32'h0;
        seen = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(imem_req, 1, 0, 0, 32'h0);
            tick();
            if (out_valid) begin
                total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL stream_pc got=%h exp=%h", out_pc, exp_pc); end
                total++; if (out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL stream_instr got=%h exp=%h", out_instr, mem_word(exp_pc)); end
                total++; if (out_pc_next !== exp_pc + 32'd4) begin bad++; $display("FAIL stream_pc_next got=%h exp=%h", out_pc_next, exp_pc + 32'd4); end
                exp_pc += 32'd4;
                seen++;
            end
        end
        total++; if (seen !== 19) begin bad++; $display("FAIL stream_rate got=%0d exp=19", seen); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(imem_req, 0, 0, 0, 32'h0);
            tick();
        end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req got=%b exp=0", imem_req); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL hold_pc got=%h exp=0", out_pc); end
        total++; if (out_instr !== mem_word(32'h0)) begin bad++; $display("FAIL hold_instr got=%h exp=%h", out_instr, mem_word(32'h0)); end
        set_in(0, 1, 0, 0, 32'h0);
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL resume_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL resume_addr got=%h exp=10", imem_addr); end
        exp_pc = 32'h4;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL resume_pc got=%h exp=%h", out_pc, exp_pc); end
                exp_pc += 32'd4;
            end
            set_in(imem_req, 1, 0, 0, 32'h0);
            tick();
        end
        total++; if (exp_pc !== 32'h34) begin bad++; $display("FAIL resume_count got=%h exp=34", exp_pc); end
    endtask

    task automatic test_drain();
        do_reset();
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        tick();
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL drain_pre_addr got=%h exp=8", imem_addr); end
        set_in(0, 0, 1, 0, 32'h100);
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_flush got=%b exp=0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL drain_hold_req got=%b exp=1", imem_req); end
            total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL drain_hold_addr got=%h exp=8", imem_addr); end
            set_in((i == 2), 0, 0, 0, 32'h0);
            tick();
        end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL drain_next_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL drain_next_addr got=%h exp=100", imem_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_dropped got=%b exp=0", out_valid); end
        set_in(1, 0, 0, 0, 32'h0);
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_first_valid got=%b exp=1", out_valid); end
        total++; if (out_pc !== 32'h100) begin bad++; $display("FAIL drain_first_pc got=%h exp=100", out_pc); end
        total++; if (out_instr !== mem_word(32'h100)) begin bad++; $display("FAIL drain_first_instr got=%h exp=%h", out_instr, mem_word(32'h100)); end
    endtask

    task automatic test_rel_redirect();
        logic found;
        found = 1'b0;
        do_reset();
        for (int i = 0; i < 40 && !found; i++) begin
            if (out_valid && out_pc == 32'h20) begin
                found = 1'b1;
            end else begin
                set_in(imem_req, 1, 0, 0, 32'h0);
                tick();
            end
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rel_reach_20 got=%b exp=1", found); end
        set_in(0, 1, 1, 1, 32'hFFFF_FFF0);
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rel_flush got=%b exp=0", out_valid); end
        set_in(1, 1, 0, 0, 32'h0);
        tick();
        total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL rel_addr got=%h exp=10", imem_addr); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rel_req got=%b exp=1", imem_req); end
        set_in(1, 0, 0, 0, 32'h0);
        tick();
        total++; if (out_pc !== 32'h10) begin bad++; $display("FAIL rel_first_pc got=%h exp=10", out_pc); end
    endtask

    task automatic test_redirect_ack();
        logic [31:0] exp_pc;
        int seen;
        do_reset();
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        tick();
        set_in(1, 0, 1, 0, 32'h200);
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rack_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL rack_addr got=%h exp=200", imem_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rack_flush got=%b exp=0", out_valid); end
        exp_pc = 32'h200;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) begin
                total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL rack_pc got=%h exp=%h", out_pc, exp_pc); end
                exp_pc += 32'd4;
                seen++;
            end
            set_in(imem_req, 1, 0, 0, 32'h0);
            tick();
        end
        total++; if (seen !== 5) begin bad++; $display("FAIL rack_count got=%0d exp=5", seen); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL areset_pre_req got=%b exp=1", imem_req); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL areset_req got=%b exp=0", imem_req); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
        tick();
        reset = 1'b0;
        // A stray ack before any request is issued must be ignored.
        set_in(1, 0, 0, 0, 32'h0);
        imem_data = 32'hDEAD_BEEF;
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL areset_first_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL areset_first_addr got=%h exp=0", imem_addr); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stray_ack_valid got=%b exp=0", out_valid); end
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL stray_ack_addr got=%h exp=0", imem_addr); end
    endtask

    // Reference: decode must see a gap-free PC sequence, restarting at the
    // redirect target, with instructions matching the memory image.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_pending;
        logic        redir_last;
        logic        a, r, rd, rel;
        logic [31:0] t;
        int accepted;
        exp_pc = 32'h0;
        prev_pending = 1'b0;
        prev_addr = 32'h0;
        redir_last = 1'b0;
        accepted = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (prev_pending) begin
                total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rnd_req_stable cyc=%0d got=%b exp=1", i, imem_req); end
                total++; if (imem_addr !== prev_addr) begin bad++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", i, imem_addr, prev_addr); end
            end
            if (redir_last) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%b exp=0", i, out_valid); end
            end
            if (out_valid) begin
                total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, out_pc, exp_pc); end
                total++; if (out_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, out_instr, mem_word(exp_pc)); end
                total++; if (out_pc_next !== exp_pc + 32'd4) begin bad++; $display("FAIL rnd_pc_next cyc=%0d got=%h exp=%h", i, out_pc_next, exp_pc + 32'd4); end
            end
            a   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rel = ($urandom_range(0, 1) == 1);
            if (rel) begin
                t = $urandom_range(0, 127);
                t = t - 32'd64;
            end else begin
                t = $urandom;
            end
            if (rd) begin
                exp_pc = (rel ? (exp_pc + t) : t) & ~32'h3;
            end else if (out_valid && r) begin
                exp_pc += 32'd4;
                accepted++;
            end
            prev_pending = imem_req && !a;
            prev_addr    = imem_addr;
            redir_last   = rd;
            set_in(a, r, rd, rel, t);
            tick();
        end
        total++; if (accepted <= 300) begin bad++; $display("FAIL rnd_progress got=%0d exp=>300", accepted); end
    endtask

    initial begin
        reset = 1'b1;
        imem_ack = 1'b0;
        imem_data = 32'h0;
        out_ready = 1'b0;
        redirect = 1'b0;
        redirect_rel = 1'b0;
        redirect_target = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_rel_redirect();
        test_redirect_ack();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_W, 32, PC/address width
- INSTR_W, 32, instruction width
- DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
- RESET_PC, 0, fetch address after reset
- PC_STEP, 4, PC increment (power of 2)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, main clock
- reset, in, 1, asynchronous active-high reset
- redirect, in, 1, branch taken; flush and refetch
- redirect_rel, in, 1, 1 = target relative to base, 0 = absolute
- redirect_target, in, ADDR_W, absolute address or two's-complement offset
- imem_req, out, 1, instruction memory request
- imem_addr, out, ADDR_W, request address
- imem_ack, in, 1, memory response valid; completes request
- imem_data, in, INSTR_W, fetched instruction
- out_valid, out, 1, head entry valid to decode
- out_ready, in, 1, decode accepts head
- out_pc, out, ADDR_W, PC of head instruction
- out_instr, out, INSTR_W, head instruction
- out_pc_next, out, ADDR_W, out_pc + PC_STEP

Function
REQ-003 Block SHALL hold fetch_pc, a DEPTH-entry FIFO of {pc, instr}, an occupancy count, and FSM states FETCH, HOLD, DRAIN.
REQ-004 At most one memory request SHALL be outstanding; imem_req and imem_addr SHALL stay stable from assertion until the cycle imem_ack is high.
REQ-005 A request SHALL start only when count + outstanding < DEPTH; otherwise FSM SHALL be HOLD with imem_req=0.
REQ-006 FETCH: imem_req=1, imem_addr=fetch_pc; on imem_ack, push {fetch_pc, imem_data} and set fetch_pc += PC_STEP (mod 2^ADDR_W).
REQ-007 After an ack, a new request MAY assert on the next cycle; back-to-back acks SHALL sustain one instruction per cycle.
REQ-008 Latency: imem_ack in cycle N SHALL give out_valid=1 with that entry in cycle N+1 when the FIFO was empty.
REQ-009 out_valid SHALL equal count != 0; out_pc, out_instr SHALL be the head entry; out_pc_next SHALL be out_pc + PC_STEP (mod 2^ADDR_W).
REQ-010 Pop SHALL occur when out_valid && out_ready && !redirect; push and pop in the same cycle SHALL leave count unchanged.
REQ-011 Redirect target SHALL be redirect_target if redirect_rel=0, else base + redirect_target (mod 2^ADDR_W), with base = out_pc if out_valid else fetch_pc; low log2(PC_STEP) bits SHALL be cleared.
REQ-012 On redirect the FIFO SHALL be flushed (out_valid=0 next cycle) and fetch_pc SHALL load the target; redirect SHALL override a same-cycle pop or push.
REQ-013 Redirect while a request is outstanding without ack SHALL enter DRAIN: imem_req held until imem_ack, response discarded, then FETCH at the new fetch_pc.
REQ-014 Redirect in the same cycle as imem_ack SHALL discard that response and go directly to FETCH at the target.
REQ-015 A second redirect during DRAIN SHALL replace fetch_pc and stay in DRAIN.
REQ-016 imem_ack while no request is outstanding SHALL be ignored.

Reset
REQ-017 reset SHALL act asynchronously: fetch_pc=RESET_PC, FIFO empty, count=0, FSM=FETCH, imem_req=0, out_valid=0, out_pc=0, out_instr=0, out_pc_next=0.
REQ-018 Reset mid-request SHALL abandon the request with no DRAIN; first request after release SHALL be RESET_PC on the first clock edge after reset deasserts.

Verification (DEPTH=4, RESET_PC=0, PC_STEP=4, ADDR_W=32)
REQ-019 Release reset, imem_ack every cycle, out_ready=1 -> out_pc 0x0,0x4,0x8,... one per cycle; out_instr matches; out_pc_next = out_pc+4.
REQ-020 out_ready=0, acks immediate -> after 4 pushes imem_req=0 (HOLD), out_pc held 0x0; raise out_ready -> refetch resumes at 0x10, no loss or duplicate.
REQ-021 Absolute redirect to 0x100 while request 0x8 pending, ack 3 cycles later -> imem_addr stays 0x8 until ack, data dropped, next imem_addr 0x100, first out_pc 0x100.
REQ-022 Relative redirect, out_pc=0x20, redirect_target=0xFFFFFFF0 -> next imem_addr 0x10; redirect with out_ready=1 same cycle -> no pop, out_valid=0 next cycle.
REQ-023 Redirect coincident with imem_ack -> that instruction never appears on out_*; next imem_addr = target.
REQ-024 Assert reset mid-FETCH, no clock edge -> imem_req=0, out_valid=0 immediately; after release first imem_addr=0x0.
